// File: rtl/mem_slave.sv
// Single-port synchronous memory slave on a valid/ready request bus with programmable wait states.
// Optional out-of-range error flag enabled by defining MEM_SLAVE_RANGE_CHK_EN.
module mem_slave #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic                    ready_q;
  logic [WIDTH-1:0]        rdata_q;

  logic                    resp_go;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]        req_wdata;
  logic                    in_range;

  // With zero wait states the response is produced from the live request on the acceptance edge.
  always_comb begin
    req_wr    = wr_q;
    req_addr  = addr_q;
    req_wdata = wdata_q;
    resp_go   = 1'b0;
    if (state_q == S_IDLE) begin
      req_wr    = wr_rd;
      req_addr  = addr;
      req_wdata = wdata;
      resp_go   = valid && (WAIT_STATES == 0);
    end else if (state_q == S_WAIT) begin
      resp_go   = (cnt_q == '0);
    end
    in_range = (32'(req_addr) < DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b0;
      if (resp_go) begin
        ready_q <= 1'b1;
        if (req_wr) begin
          if (in_range) begin
            mem_q[req_addr] <= req_wdata;
          end
        end else begin
          rdata_q <= in_range ? mem_q[req_addr] : '0;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            wr_q    <= wr_rd;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              cnt_q   <= CNT_W'(WAIT_STATES - 1);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_SLAVE_RANGE_CHK_EN
  logic err_q;

  // Error travels with the ready pulse and clears with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= resp_go && !in_range;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_slave.sv
// Bench for mem_slave: three instances (0, 3 and 2 wait states; one with DEPTH=12) checked
// against an array-based memory model. Honours MEM_SLAVE_RANGE_CHK_EN for err expectations.
module tb_mem_slave;

`ifdef MEM_SLAVE_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       valid [3];
  logic       wr_rd [3];
  logic [3:0] addr  [3];
  logic [7:0] wdata [3];
  logic       ready [3];
  logic [7:0] rdata [3];
  logic       err   [3];

  int ws_m    [3] = '{0, 3, 2};
  int depth_m [3] = '{16, 12, 16};
  logic [7:0] mem_m [3][16];
  logic [7:0] last_rd [3];

  int total = 0;
  int bad   = 0;

  mem_slave #(.WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .valid(valid[0]), .wr_rd(wr_rd[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]));

  mem_slave #(.WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .valid(valid[1]), .wr_rd(wr_rd[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]));

  mem_slave #(.WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .valid(valid[2]), .wr_rd(wr_rd[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ready(ready[2]), .rdata(rdata[2]), .err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void clear_model();
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 8'h00;
      for (int a = 0; a < 16; a++) mem_m[i][a] = 8'h00;
    end
  endfunction

  // Memory semantics: in-range writes stick, out-of-range writes vanish, out-of-range reads give 0.
  function automatic void model(input int i, input bit wr, input int a, input logic [7:0] d,
                                output logic [7:0] erd, output bit eer);
    if (wr) begin
      if (a < depth_m[i]) mem_m[i][a] = d;
    end else begin
      last_rd[i] = (a < depth_m[i]) ? mem_m[i][a] : 8'h00;
    end
    erd = last_rd[i];
    eer = RANGE_CHK && (a >= depth_m[i]);
  endfunction

  // Issue one request and wait (bounded) for ready; lat counts edges from acceptance, inclusive.
  task automatic drive(input int i, input bit wr, input logic [3:0] a, input logic [7:0] d,
                       input bit scramble, output int lat, output logic [7:0] rd,
                       output logic er, output bit to);
    valid[i] = 1'b1;
    wr_rd[i] = wr;
    addr[i]  = a;
    wdata[i] = d;
    lat = 0;
    to  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble) begin
        addr[i]  = 4'($urandom);
        wdata[i] = 8'($urandom);
        wr_rd[i] = 1'($urandom);
      end
      if (ready[i]) begin
        to = 1'b0;
        break;
      end
    end
    valid[i] = 1'b0;
    rd = rdata[i];
    er = err[i];
  endtask

  task automatic test_reset();
    int lat; logic [7:0] rd; logic er; bit to; logic [7:0] erd; bit eer;
    drive(1, 1'b1, 4'd5, 8'h5A, 1'b0, lat, rd, er, to);
    model(1, 1'b1, 5, 8'h5A, erd, eer);
    @(posedge clk); #1;
    valid[1] = 1'b1; wr_rd[1] = 1'b0; addr[1] = 4'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ready[i] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 0", i, ready[i]); end
      total++;
      if (rdata[i] !== 8'h00) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 00", i, rdata[i]); end
      total++;
      if (err[i] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", i, err[i]); end
    end
    valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    drive(1, 1'b0, 4'd5, 8'h00, 1'b0, lat, rd, er, to);
    model(1, 1'b0, 5, 8'h00, erd, eer);
    total++;
    if (to || rd !== erd) begin bad++; $display("FAIL reset_read5: got %h want %h (timeout=%0b)", rd, erd, to); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd; logic er; bit to; logic [7:0] erd; bit eer;
    drive(0, 1'b1, 4'd3, 8'hA5, 1'b0, lat, rd, er, to);
    model(0, 1'b1, 3, 8'hA5, erd, eer);
    total++;
    if (to || lat != 1) begin bad++; $display("FAIL wr_latency_ws0: got %0d want 1 (timeout=%0b)", lat, to); end
    @(posedge clk); #1;
    total++;
    if (ready[0] !== 1'b0) begin bad++; $display("FAIL wr_pulse_ws0: ready got %b want 0", ready[0]); end
    drive(0, 1'b0, 4'd3, 8'h00, 1'b0, lat, rd, er, to);
    model(0, 1'b0, 3, 8'h00, erd, eer);
    total++;
    if (to || rd !== erd) begin bad++; $display("FAIL raw_ws0: got %h want %h", rd, erd); end
    total++;
    if (lat != 1) begin bad++; $display("FAIL rd_latency_ws0: got %0d want 1", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states();
    int lat; logic [7:0] rd; logic er; bit to; logic [7:0] erd; bit eer;
    drive(1, 1'b1, 4'd9, 8'h3C, 1'b0, lat, rd, er, to);
    model(1, 1'b1, 9, 8'h3C, erd, eer);
    @(posedge clk); #1;
    drive(1, 1'b0, 4'd9, 8'h00, 1'b1, lat, rd, er, to);
    model(1, 1'b0, 9, 8'h00, erd, eer);
    total++;
    if (to || lat != 4) begin bad++; $display("FAIL latency_ws3: got %0d want 4 (timeout=%0b)", lat, to); end
    total++;
    if (rd !== erd) begin bad++; $display("FAIL scrambled_read_ws3: got %h want %h", rd, erd); end
    @(posedge clk); #1;
    total++;
    if (ready[1] !== 1'b0) begin bad++; $display("FAIL pulse_ws3: ready got %b want 0", ready[1]); end
  endtask

  // Valid held high: ready must appear once per (ws+2) edges, never re-accepting in RESP.
  task automatic test_held(input int i);
    int per;
    logic [7:0] erd; bit eer;
    per = ws_m[i] + 2;
    valid[i] = 1'b1; wr_rd[i] = 1'b1; addr[i] = 4'd7; wdata[i] = 8'h11;
    for (int k = 0; k < 3 * per; k++) begin
      @(posedge clk); #1;
      total++;
      if (ready[i] !== ((k % per) == ws_m[i])) begin
        bad++;
        $display("FAIL held_valid[%0d] edge %0d: ready got %b want %b", i, k, ready[i], (k % per) == ws_m[i]);
      end
    end
    valid[i] = 1'b0;
    model(i, 1'b1, 7, 8'h11, erd, eer);
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [7:0] rd; logic er; bit to; logic [7:0] erd; bit eer;
    valid[2] = 1'b1; wr_rd[2] = 1'b1; addr[2] = 4'd2; wdata[2] = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    drive(2, 1'b0, 4'd2, 8'h00, 1'b0, lat, rd, er, to);
    model(2, 1'b0, 2, 8'h00, erd, eer);
    total++;
    if (to || rd !== erd) begin bad++; $display("FAIL abort_write: got %h want %h (timeout=%0b)", rd, erd, to); end
    total++;
    if (lat != 3) begin bad++; $display("FAIL latency_ws2: got %0d want 3", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_range();
    int lat; logic [7:0] rd; logic er; bit to; logic [7:0] erd; bit eer;
    drive(1, 1'b1, 4'd13, 8'h55, 1'b0, lat, rd, er, to);
    model(1, 1'b1, 13, 8'h55, erd, eer);
    total++;
    if (to || er !== eer) begin bad++; $display("FAIL range_wr_err: got %b want %b", er, eer); end
    @(posedge clk); #1;
    total++;
    if (err[1] !== 1'b0) begin bad++; $display("FAIL range_err_clear: got %b want 0", err[1]); end
    drive(1, 1'b0, 4'd13, 8'h00, 1'b0, lat, rd, er, to);
    model(1, 1'b0, 13, 8'h00, erd, eer);
    total++;
    if (to || rd !== erd) begin bad++; $display("FAIL range_rd_data: got %h want %h", rd, erd); end
    total++;
    if (er !== eer) begin bad++; $display("FAIL range_rd_err: got %b want %b", er, eer); end
    @(posedge clk); #1;
    drive(1, 1'b0, 4'd1, 8'h00, 1'b0, lat, rd, er, to);
    model(1, 1'b0, 1, 8'h00, erd, eer);
    total++;
    if (to || rd !== erd || er !== eer) begin
      bad++; $display("FAIL range_no_alias: got %h/%b want %h/%b", rd, er, erd, eer);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back(input int i, input int n);
    int lat; logic [7:0] rd; logic er; bit to; logic [7:0] erd; bit eer;
    bit wr; logic [3:0] a; logic [7:0] d;
    for (int t = 0; t < n; t++) begin
      wr = 1'($urandom);
      a  = 4'($urandom);
      d  = 8'($urandom);
      drive(i, wr, a, d, 1'($urandom), lat, rd, er, to);
      model(i, wr, int'(a), d, erd, eer);
      total++;
      if (to || lat != ws_m[i] + 1) begin
        bad++; $display("FAIL b2b_latency[%0d] #%0d: got %0d want %0d", i, t, lat, ws_m[i] + 1);
      end
      total++;
      if (rd !== erd) begin bad++; $display("FAIL b2b_rdata[%0d] #%0d a=%0d: got %h want %h", i, t, a, rd, erd); end
      total++;
      if (er !== eer) begin bad++; $display("FAIL b2b_err[%0d] #%0d a=%0d: got %b want %b", i, t, a, er, eer); end
      @(posedge clk); #1;
      total++;
      if (ready[i] !== 1'b0) begin bad++; $display("FAIL b2b_pulse[%0d] #%0d: ready got %b want 0", i, t, ready[i]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; wr_rd[i] = 1'b0; addr[i] = 4'd0; wdata[i] = 8'h00;
    end
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_wait_states();
    test_held(0);
    test_held(2);
    test_reset_mid_wait();
    test_range();
    for (int i = 0; i < 3; i++) test_back_to_back(i, 25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_slave.md
# mem_slave

Single-port synchronous memory slave answering the `valid`/`ready` request bus of the memory subsystem. It sits directly downstream of the memory bus master and drives `ready` and `rdata` on the same interface that the protocol checker monitors. Each request is a write or a read. The response comes back after a programmable number of wait states, as a one-cycle `ready` pulse.

## Interface
- `WIDTH`, 8: data word width in bits.
- `ADDR_WIDTH`, 4: address width in bits.
- `DEPTH`, 16: number of words; must be ≤ 2**ADDR_WIDTH.
- `WAIT_STATES`, 1: extra cycles inserted between acceptance and response; range 0–15.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low (`rst==0` resets).
- `valid`, in, 1: request valid; master holds it and the request fields stable until `ready`.
- `wr_rd`, in, 1: 1 = write, 0 = read.
- `addr`, in, ADDR_WIDTH: word address.
- `wdata`, in, WIDTH: write data.
- `ready`, out, 1: one-cycle response pulse; marks the request done.
- `rdata`, out, WIDTH: read data; valid when `ready` is high after a read, then holds.
- `err`, out, 1: out-of-range flag, qualified by `ready`; see Configuration.

## Operation
States: IDLE, WAIT, RESP. Reset state is IDLE.

- **Reset:** `ready`=0, `rdata`=0, `err`=0, wait counter 0, all DEPTH words cleared to 0. Reset asserted mid-transaction aborts it; no partial write occurs.
- **IDLE:**
  - If `valid`=1: latch `wr_rd`, `addr`, `wdata`.
  - WAIT_STATES=0: go to RESP.
  - Otherwise: load counter with WAIT_STATES−1 and go to WAIT.
  - If `valid`=0: stay in IDLE.
- **WAIT:** decrement the counter. When it reads 0, go to RESP. Input changes are ignored because the request is already latched.
- **Transition into RESP** (the same edge):
  - Write: `mem[addr] <= wdata`; `rdata` unchanged.
  - Read: `rdata <= mem[addr]`.
  - `ready` <= 1.
- **RESP:** `ready` <= 0 and go to IDLE. `valid` is not sampled in this state, so a held request cannot be accepted twice.
- **Out-of-range address (`addr` ≥ DEPTH):** the write is dropped, and a read returns 0.

## Timing
- Acceptance edge: `valid` sampled 1 in IDLE. `ready` goes high 1+WAIT_STATES cycles later and stays high for exactly 1 cycle.
- With WAIT_STATES=0, `ready` is high in the cycle right after acceptance, so `valid |=> ready` holds.
- Throughput: one transaction per 2+WAIT_STATES cycles. A back-to-back request (valid re-asserted or held after `ready`) is accepted at the edge ending RESP+1, i.e. the first IDLE edge.
- Read-after-write to the same address returns the new data. A write completes at the RESP-entry edge, before any later read samples memory.
- `ready`, `rdata` and `err` are registered; there are no combinational input-to-output paths.
- `rdata` is never X after reset.

## Configuration
- Macro: `MEM_SLAVE_RANGE_CHK_EN`.
- **Defined:** an access with `addr` ≥ DEPTH drives `err`=1 together with its `ready` pulse. `err` returns to 0 with `ready`. Memory is unchanged and `rdata` is 0 for such a read.
- **Undefined:** `err` is tied to 0 and there is no range-compare logic. The drop-write / read-0 behaviour for out-of-range addresses still applies.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles mid-read. Required: `ready`=0, `rdata`=0, `err`=0. A later read of address 5 returns 0.
- **Write then read (WAIT_STATES=0):**
  - Write `addr`=3, `wdata`=0xA5. Required: `ready` pulses 1 cycle after acceptance.
  - Read `addr`=3. Required: `rdata`=0xA5 with `ready`.
- **Wait states (WAIT_STATES=3):**
  - Read: `ready` rises exactly 4 cycles after the acceptance edge and is high for 1 cycle.
  - Changing `addr` during WAIT does not alter the result.
- **Held `valid` across the response:** write 0x11 to address 7 and keep `valid` high for 6 cycles. Required: one `ready` pulse per 2+WAIT_STATES cycles, with no acceptance in RESP.
- **Reset mid-WAIT (WAIT_STATES=2):** a write of 0xFF to address 2 is interrupted by reset. A later read of address 2 returns 0.
- **Range check (DEPTH=12, `MEM_SLAVE_RANGE_CHK_EN` defined):**
  - Write 0x55 to address 13: `err`=1 with `ready`.
  - Read address 13: `rdata`=0, `err`=1.
  - With the macro undefined: `err` stays 0 throughout.
